// File: rtl/store_unit_pkg.sv
// Shared definitions for the RV32I store path.
// STORE_UNIT_MISALIGN_EN adds the BEAT1 state used by word-crossing stores.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
`ifdef STORE_UNIT_MISALIGN_EN
        BEAT1,
`endif
        RESP,
        ERR
    } state_e;

    function automatic logic [3:0] base_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   base_mask = 4'b0001;
            F3_SH:   base_mask = 4'b0011;
            F3_SW:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] funct3);
        f3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and memory-write bus of the store unit.
// slave = store_unit side, master = execute stage / memory side.
interface store_unit_if #(parameter int unsigned ADDR_W = 32);

    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_data;
    logic [2:0]        i_funct3;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic              i_mem_ack;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_valid, i_addr, i_data, i_funct3, i_mem_ack,
        output o_ready, o_mem_req, o_mem_addr, o_mem_wdata, o_mem_be, o_done, o_err
    );

    modport master (
        output i_valid, i_addr, i_data, i_funct3, i_mem_ack,
        input  o_ready, o_mem_req, o_mem_addr, o_mem_wdata, o_mem_be, o_done, o_err
    );

endinterface

// File: rtl/store_unit_align.sv
// Combinational lane alignment: places masked store data into one or two
// word images with matching byte enables. The second image only exists
// when STORE_UNIT_MISALIGN_EN is defined.
module store_align
    import store_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  mask_i,
    output logic [31:0] wdata0_o,
    output logic [3:0]  be0_o,
`ifdef STORE_UNIT_MISALIGN_EN
    output logic [31:0] wdata1_o,
`endif
    output logic [3:0]  be1_o
);

    logic [31:0] lane_data;
    logic [7:0]  m8;
`ifdef STORE_UNIT_MISALIGN_EN
    logic [63:0] shifted;
`endif

    // Zero the insignificant source bytes, then shift data and mask into place.
    always_comb begin
        lane_data = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            lane_data[8*n +: 8] = mask_i[n] ? data_i[8*n +: 8] : 8'h00;
        end
        m8    = {4'b0000, mask_i} << off_i;
        be0_o = m8[3:0];
        be1_o = m8[7:4];
`ifdef STORE_UNIT_MISALIGN_EN
        shifted  = {32'h0, lane_data} << {off_i, 3'b000};
        wdata0_o = shifted[31:0];
        wdata1_o = shifted[63:32];
`else
        wdata0_o = lane_data << {off_i, 3'b000};
`endif
    end

endmodule

// File: rtl/store_unit.sv
// RV32I store unit: accepts SB/SH/SW, issues one or two aligned word writes
// over a req/ack bus, then pulses o_done (or o_err for illegal requests).
// STORE_UNIT_MISALIGN_EN: word-crossing stores are split into two beats;
// without it they are rejected with o_err and no beat is issued.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    store_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef STORE_UNIT_MISALIGN_EN
    logic [31:0]       wdata1_q, wdata1_d;
    logic [3:0]        be1_q, be1_d;
    logic [31:0]       al_wdata1;
`endif

    logic [31:0] al_wdata0;
    logic [3:0]  al_be0, al_be1;
    logic        bad_req;

    store_align u_align (
        .data_i   (bus.i_data),
        .off_i    (bus.i_addr[1:0]),
        .mask_i   (base_mask(bus.i_funct3)),
        .wdata0_o (al_wdata0),
        .be0_o    (al_be0),
`ifdef STORE_UNIT_MISALIGN_EN
        .wdata1_o (al_wdata1),
`endif
        .be1_o    (al_be1)
    );

    // Classify the incoming request as unsupported.
    always_comb begin
        bad_req = !f3_legal(bus.i_funct3);
`ifndef STORE_UNIT_MISALIGN_EN
        if ((al_be1 != 4'b0000) ||
            ((bus.i_funct3 == F3_SH) && bus.i_addr[0]) ||
            ((bus.i_funct3 == F3_SW) && (bus.i_addr[1:0] != 2'b00))) begin
            bad_req = 1'b1;
        end
`endif
    end

    // Next state and next registered outputs; bus fields are zero unless a beat is pending.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        req_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef STORE_UNIT_MISALIGN_EN
        wdata1_d = wdata1_q;
        be1_d    = be1_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.i_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (bad_req) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BEAT0;
                        req_d   = 1'b1;
                        addr_d  = {bus.i_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = al_wdata0;
                        be_d    = al_be0;
`ifdef STORE_UNIT_MISALIGN_EN
                        wdata1_d = al_wdata1;
                        be1_d    = al_be1;
`endif
                    end
                end
            end
            BEAT0: begin
                if (bus.i_mem_ack) begin
`ifdef STORE_UNIT_MISALIGN_EN
                    if (be1_q != 4'b0000) begin
                        state_d = BEAT1;
                        req_d   = 1'b1;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = wdata1_q;
                        be_d    = be1_q;
                    end else begin
                        state_d = RESP;
                        done_d  = 1'b1;
                    end
`else
                    state_d = RESP;
                    done_d  = 1'b1;
`endif
                end else begin
                    req_d   = 1'b1;
                    addr_d  = addr_q;
                    wdata_d = wdata_q;
                    be_d    = be_q;
                end
            end
`ifdef STORE_UNIT_MISALIGN_EN
            BEAT1: begin
                if (bus.i_mem_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = addr_q;
                    wdata_d = wdata_q;
                    be_d    = be_q;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            ERR: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef STORE_UNIT_MISALIGN_EN
            wdata1_q <= '0;
            be1_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef STORE_UNIT_MISALIGN_EN
            wdata1_q <= wdata1_d;
            be1_q    <= be1_d;
`endif
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_mem_req   = req_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_be    = be_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule
